// File: rtl/ultra_sonic_pkg.sv
// Shared types and constants for the ultrasonic echo-count filter.
// Centimetre conversion is a fixed-point multiply: dist = (avg * CM_MULT + CM_ROUND) >> CM_SHIFT.
package ultra_sonic_pkg;

    localparam int COUNT_WIDTH = 32;
    localparam int PROD_WIDTH  = 46;
    localparam int CM_MULT     = 11570;   // round(2^24 / 1450): 40 ns per count, 58 us per cm
    localparam int CM_SHIFT    = 24;
    localparam int CM_ROUND    = 1 << 23;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CHECK  = 3'd2,
        S_ACCUM  = 3'd3,
        S_CONV   = 3'd4,
        S_PUB    = 3'd5
    } state_t;

endpackage

// File: rtl/ultra_sonic_avg_buffer.sv
// Circular buffer of the last 2^AVG_LOG2 accepted echo counts with a running sum.
// The sum swaps out the oldest entry on each push, so it never needs a full re-add.
module ultra_sonic_avg_buffer
    import ultra_sonic_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                            clk,
    input  logic                            reset_l,
    input  logic                            push,
    input  logic [COUNT_WIDTH-1:0]          push_data,
    output logic [COUNT_WIDTH+AVG_LOG2-1:0] sum,
    output logic                            full
);

    localparam int WINDOW = 1 << AVG_LOG2;
    localparam logic [AVG_LOG2:0] FILL_MAX = (AVG_LOG2 + 1)'(WINDOW);

    logic [COUNT_WIDTH-1:0] buf_mem [WINDOW];
    logic [AVG_LOG2-1:0]    wr_ptr;
    logic [AVG_LOG2:0]      fill;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < WINDOW; i++) begin
                buf_mem[i] <= '0;
            end
            sum    <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (push) begin
            // Entries start at zero, so subtracting the slot is correct while filling too.
            sum <= sum - {{AVG_LOG2{1'b0}}, buf_mem[wr_ptr]} + {{AVG_LOG2{1'b0}}, push_data};
            buf_mem[wr_ptr] <= push_data;
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    assign full = (fill == FILL_MAX);

endmodule

// File: rtl/ultra_sonic_filter.sv
// Captures one echo count per measurement, rejects out-of-range counts, averages the good ones
// and publishes average count, distance in cm and a proximity flag with a one-cycle strobe.
module ultra_sonic_filter
    import ultra_sonic_pkg::*;
#(
    parameter int AVG_LOG2  = 3,
    parameter int MIN_COUNT = 2900,
    parameter int MAX_COUNT = 600000,
    parameter int NEAR_CM   = 30
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [31:0] sample_data,
    input  logic        sample_valid,
    output logic [31:0] avg_count,
    output logic [15:0] dist_cm,
    output logic        near,
    output logic        out_valid,
    output logic [15:0] err_count,
    output logic [2:0]  dbg_state
);

    localparam int SUM_WIDTH  = COUNT_WIDTH + AVG_LOG2;
    localparam int DIST_WIDTH = PROD_WIDTH - CM_SHIFT;

    state_t                 state, state_next;
    logic                   valid_q, rise_q;
    logic [COUNT_WIDTH-1:0] sample_q, avg_q, avg_next;
    logic [PROD_WIDTH-1:0]  prod_q, prod_rnd;
    logic [SUM_WIDTH-1:0]   sum;
    logic                   full, in_range;
    logic                   capture, reject, push, convert, publish;
    logic [DIST_WIDTH-1:0]  dist_wide;
    logic [15:0]            dist_sat;

    // Handshake: sample_valid is a level held for many cycles per measurement. Only its registered
    // rising edge starts a measurement, and only from S_IDLE; sample_data is taken one cycle later
    // because the upstream register settles after valid. out_valid is a single-cycle strobe with no
    // back-pressure; the published outputs hold between strobes.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            valid_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            valid_q <= sample_valid;
            rise_q  <= sample_valid & ~valid_q;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign in_range = (sample_q >= COUNT_WIDTH'(MIN_COUNT)) && (sample_q <= COUNT_WIDTH'(MAX_COUNT));

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        reject     = 1'b0;
        push       = 1'b0;
        convert    = 1'b0;
        publish    = 1'b0;
        case (state)
            S_IDLE:   if (rise_q) state_next = S_SETTLE;
            S_SETTLE: begin
                capture    = 1'b1;
                state_next = S_CHECK;
            end
            S_CHECK: begin
                if (in_range) begin
                    state_next = S_ACCUM;
                end else begin
                    reject     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_ACCUM: begin
                push       = 1'b1;
                state_next = S_CONV;
            end
            S_CONV: begin
                convert    = 1'b1;
                state_next = S_PUB;
            end
            S_PUB: begin
                publish    = 1'b1;
                state_next = S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    ultra_sonic_avg_buffer #(.AVG_LOG2(AVG_LOG2)) u_avg_buffer (
        .clk       (clk),
        .reset_l   (reset_l),
        .push      (push),
        .push_data (sample_q),
        .sum       (sum),
        .full      (full)
    );

    assign avg_next  = COUNT_WIDTH'(sum >> AVG_LOG2);
    assign prod_rnd  = prod_q + PROD_WIDTH'(CM_ROUND);
    assign dist_wide = prod_rnd[PROD_WIDTH-1:CM_SHIFT];
    assign dist_sat  = (dist_wide > DIST_WIDTH'(16'hFFFF)) ? 16'hFFFF : dist_wide[15:0];

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sample_q  <= '0;
            avg_q     <= '0;
            prod_q    <= '0;
            avg_count <= '0;
            dist_cm   <= '0;
            near      <= 1'b0;
            out_valid <= 1'b0;
            err_count <= '0;
        end else begin
            out_valid <= 1'b0;
            if (capture) begin
                sample_q <= sample_data;
            end
            if (reject && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (convert) begin
                avg_q  <= avg_next;
                prod_q <= PROD_WIDTH'(avg_next) * PROD_WIDTH'(CM_MULT);
            end
            // Nothing is published until the window holds a full set of good samples.
            if (publish && full) begin
                avg_count <= avg_q;
                dist_cm   <= dist_sat;
                near      <= (dist_sat < 16'(NEAR_CM));
                out_valid <= 1'b1;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_ultra_sonic_filter.sv
// Self-checking bench for ultra_sonic_filter: a reference window model pushes expected
// {avg_count, dist_cm, near} on every accepted sample of a full window; a monitor pops on out_valid.
module tb_ultra_sonic_filter;
    import ultra_sonic_pkg::*;

    localparam int          WINDOW  = 8;
    localparam logic [31:0] MIN_CNT = 32'd2900;
    localparam logic [31:0] MAX_CNT = 32'd600000;

    logic        clk;
    logic        reset_l;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic [31:0] avg_count;
    logic [15:0] dist_cm;
    logic        near;
    logic        out_valid;
    logic [15:0] err_count;
    logic [2:0]  dbg_state;

    int          checks;
    int          errors;
    int          exp_err;
    logic [48:0] exp_q[$];
    logic [31:0] win[$];
    logic [31:0] last_avg;
    logic [15:0] last_dist;
    logic        last_near;

    ultra_sonic_filter dut (
        .clk          (clk),
        .reset_l      (reset_l),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .avg_count    (avg_count),
        .dist_cm      (dist_cm),
        .near         (near),
        .out_valid    (out_valid),
        .err_count    (err_count),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model of the published result for the current window
    function automatic logic [48:0] model_out();
        longint unsigned s;
        longint unsigned p;
        logic [31:0]     a;
        logic [15:0]     d;
        s = 0;
        foreach (win[i]) s += win[i];
        a = 32'(s / WINDOW);
        p = (longint'(a) * 11570 + 64'd8388608) >> 24;
        d = (p > 64'd65535) ? 16'hFFFF : 16'(p);
        return {a, d, (d < 16'd30)};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        logic [48:0] e;
        if (reset_l && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe avg=%0d dist=%0d near=%0b", avg_count, dist_cm, near);
            end else begin
                e = exp_q.pop_front();
                if ({avg_count, dist_cm, near} !== e) begin
                    errors++;
                    $display("FAIL strobe_data got avg=%0d dist=%0d near=%0b exp avg=%0d dist=%0d near=%0b",
                             avg_count, dist_cm, near, e[48:17], e[16:1], e[0]);
                end
                last_avg  = e[48:17];
                last_dist = e[16:1];
                last_near = e[0];
            end
        end
    end

    // driver: one measurement, with cycle-exact strobe timing and err_count checks
    task automatic drive_measurement(input logic [31:0] data, input int high_cycles, input int low_cycles);
        logic        good;
        logic        strobe;
        logic [31:0] tmp;
        good   = (data >= MIN_CNT) && (data <= MAX_CNT);
        strobe = 1'b0;
        if (good) begin
            win.push_back(data);
            if (win.size() > WINDOW) tmp = win.pop_front();
            if (win.size() == WINDOW) begin
                strobe = 1'b1;
                exp_q.push_back(model_out());
            end
        end else if (exp_err < 65535) begin
            exp_err++;
        end
        @(negedge clk);
        sample_data  = data;
        sample_valid = 1'b1;
        for (int j = 0; j < high_cycles + low_cycles; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== (strobe && (j == 6))) begin
                errors++;
                $display("FAIL strobe_timing data=%0d cycle=%0d got=%b exp=%b", data, j, out_valid, strobe && (j == 6));
            end
            if (j == high_cycles - 1) sample_valid = 1'b0;
        end
        checks++;
        if (err_count !== 16'(exp_err)) begin
            errors++;
            $display("FAIL err_count data=%0d got=%0d exp=%0d", data, err_count, exp_err);
        end
    endtask

    task automatic test_reset();
        reset_l      = 1'b0;
        sample_data  = '0;
        sample_valid = 1'b0;
        exp_err      = 0;
        repeat (3) @(negedge clk);
        reset_l = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (avg_count !== 32'd0) begin errors++; $display("FAIL reset_avg got=%0d exp=0", avg_count); end
        if (dist_cm !== 16'd0) begin errors++; $display("FAIL reset_dist got=%0d exp=0", dist_cm); end
        if (near !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags near=%b out_valid=%b exp 0 0", near, out_valid);
        end
        if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        if (dbg_state !== 3'(S_IDLE)) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < WINDOW; i++) drive_measurement(32'd14500, 100, 20);
        checks++;
        if (avg_count !== 32'd14500 || dist_cm !== 16'd10 || near !== 1'b1) begin
            errors++;
            $display("FAIL fill_result got avg=%0d dist=%0d near=%b exp 14500 10 1", avg_count, dist_cm, near);
        end
    endtask

    task automatic test_far();
        for (int i = 0; i < WINDOW; i++) drive_measurement(32'd580000, 20, 10);
        checks++;
        if (avg_count !== 32'd580000 || dist_cm !== 16'd400 || near !== 1'b0) begin
            errors++;
            $display("FAIL far_result got avg=%0d dist=%0d near=%b exp 580000 400 0", avg_count, dist_cm, near);
        end
        drive_measurement(32'd14500, 20, 10);
        checks++;
        if (avg_count !== 32'd509312 || dist_cm !== 16'd351 || near !== 1'b0) begin
            errors++;
            $display("FAIL mixed_result got avg=%0d dist=%0d near=%b exp 509312 351 0", avg_count, dist_cm, near);
        end
    endtask

    task automatic test_reject();
        drive_measurement(32'd2899, 20, 10);
        drive_measurement(32'd600001, 20, 10);
        drive_measurement(32'd0, 20, 10);
        checks += 2;
        if (err_count !== 16'd3) begin errors++; $display("FAIL reject_count got=%0d exp=3", err_count); end
        if (avg_count !== last_avg || dist_cm !== last_dist || near !== last_near) begin
            errors++;
            $display("FAIL reject_hold got avg=%0d dist=%0d exp avg=%0d dist=%0d", avg_count, dist_cm, last_avg, last_dist);
        end
        drive_measurement(MIN_CNT, 20, 10);
        drive_measurement(MAX_CNT, 20, 10);
    endtask

    task automatic test_rise_in_check();
        logic [31:0] tmp;
        win.push_back(32'd100000);
        if (win.size() > WINDOW) tmp = win.pop_front();
        exp_q.push_back(model_out());
        @(negedge clk);
        sample_data  = 32'd100000;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_data = 32'd5;
        repeat (20) @(negedge clk);
        sample_valid = 1'b0;
        repeat (20) @(negedge clk);
        checks += 2;
        if (err_count !== 16'(exp_err)) begin
            errors++; $display("FAIL rise_in_check_err got=%0d exp=%0d", err_count, exp_err);
        end
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rise_in_check_strobe pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_err_saturate();
        for (int n = 0; n < 65536; n++) begin
            @(negedge clk);
            sample_data  = 32'd1;
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            @(negedge clk);
        end
        exp_err = 65535;
        repeat (10) @(negedge clk);
        checks++;
        if (err_count !== 16'hFFFF) begin errors++; $display("FAIL err_saturate got=%0h exp=ffff", err_count); end
        drive_measurement(32'd700000, 10, 10);
        drive_measurement(32'd1000, 10, 10);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive_measurement(32'($urandom_range(2900, 600000)), 12, 8);
        @(negedge clk);
        sample_data  = 32'd14500;
        sample_valid = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (dbg_state !== 3'(S_ACCUM)) begin errors++; $display("FAIL reset_mid_state got=%0d exp=%0d", dbg_state, S_ACCUM); end
        reset_l      = 1'b0;
        sample_valid = 1'b0;
        #1;
        checks++;
        if (avg_count !== 32'd0 || dist_cm !== 16'd0 || near !== 1'b0 || out_valid !== 1'b0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got avg=%0d dist=%0d near=%b ov=%b err=%0d exp all 0",
                     avg_count, dist_cm, near, out_valid, err_count);
        end
        win.delete();
        exp_q.delete();
        exp_err = 0;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        for (int i = 0; i < WINDOW; i++) drive_measurement(32'($urandom_range(2900, 600000)), 12, 8);
    endtask

    // watchdog
    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_far();
        test_reject();
        test_rise_in_check();
        test_err_saturate();
        test_reset_mid();
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue pending=%0d exp=0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
